rvvi_ack_receiver: RTL and testbench

RVVI_ACK_RECEIVER -- requirements
Module: rvvi_ack_receiver

---
 rtl/rvvi_ack_receiver.sv | 207 ++++++++++++++++++++
 tb/tb_rvvi_ack_receiver.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rvvi_ack_receiver.sv
// rtl/rvvi_ack_receiver.sv - receives acknowledgement frames from the MAC RX stream and validates them
//
// Purpose:
//   Parses Ethernet-style acknowledgement frames arriving one 32-bit word per
//   transfer. The block checks the destination and source MACs, both type
//   fields, and the byte strobes. When a frame passes every check, it presents
//   the frame count on the Ack handshake. Frames that fail a check are counted
//   in DropCount.
//
// Ports:
//   clk, resetn         - clock (rising edge) and asynchronous active-low reset
//   RvviAxiRdata/Rstrb  - received word and its byte enables
//   RvviAxiRlast        - final word of the frame
//   RvviAxiRvalid/Rready- word handshake (ready is low only while an ack is held)
//   LocalMac, RemoteMac - expected destination / source addresses
//   EthType, AckType    - expected type fields
//   AckValid/AckReady   - acknowledgement handshake
//   AckFrameCount       - count carried by the last validated frame
//   DropCount           - saturating count of rejected frames
module rvvi_ack_receiver #(
  parameter int FRAME_COUNT_WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [31:0]                  RvviAxiRdata,
  input  logic [3:0]                   RvviAxiRstrb,
  input  logic                         RvviAxiRlast,
  input  logic                         RvviAxiRvalid,
  output logic                         RvviAxiRready,
  input  logic [47:0]                  LocalMac,
  input  logic [47:0]                  RemoteMac,
  input  logic [15:0]                  EthType,
  input  logic [15:0]                  AckType,
  output logic                         AckValid,
  input  logic                         AckReady,
  output logic [FRAME_COUNT_WIDTH-1:0] AckFrameCount,
  output logic [15:0]                  DropCount
);

  localparam int CountWords = FRAME_COUNT_WIDTH / 32;
  localparam logic [2:0] PayloadEnd = 3'(3 + CountWords);
  localparam logic [2:0] IdxSat     = 3'(4 + CountWords);

  typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, DRAIN, HOLD} stateT;

  // Mismatch flag bit positions. Destination passes if either the unicast
  // or the broadcast comparison never failed, so both are tracked separately.
  localparam int FlagLocal = 0;
  localparam int FlagBcast = 1;
  localparam int FlagSrc   = 2;
  localparam int FlagType  = 3;
  localparam int FlagStrb  = 4;

  stateT                         state;
  stateT                         stateNxt;
  logic [2:0]                    wordIdx;
  logic [4:0]                    misFlags;
  logic [4:0]                    wordMis;
  logic [4:0]                    flagsNxt;
  logic                          frameOk;
  logic                          xfer;
  logic                          dropEvt;
  logic                          holdEvt;
  logic [FRAME_COUNT_WIDTH-1:0]  countShadow;
  logic [FRAME_COUNT_WIDTH-1:0]  countNxt;
  logic [FRAME_COUNT_WIDTH-1:0]  ackCountQ;
  logic [15:0]                   dropCntQ;

  assign xfer          = RvviAxiRvalid && RvviAxiRready;
  assign AckFrameCount = ackCountQ;
  assign DropCount     = dropCntQ;

  // Per-word checks. Words past PayloadEnd are not inspected at all.
  always_comb begin
    wordMis = '0;
    if (wordIdx <= PayloadEnd) begin
      wordMis[FlagStrb] = (RvviAxiRstrb != 4'hF);
      case (wordIdx)
        3'd0: begin
          wordMis[FlagLocal] = (RvviAxiRdata != LocalMac[31:0]);
          wordMis[FlagBcast] = (RvviAxiRdata != 32'hFFFF_FFFF);
        end
        3'd1: begin
          wordMis[FlagLocal] = (RvviAxiRdata[15:0] != LocalMac[47:32]);
          wordMis[FlagBcast] = (RvviAxiRdata[15:0] != 16'hFFFF);
          wordMis[FlagSrc]   = (RvviAxiRdata[31:16] != RemoteMac[15:0]);
        end
        3'd2: wordMis[FlagSrc]  = (RvviAxiRdata != RemoteMac[47:16]);
        3'd3: wordMis[FlagType] = (RvviAxiRdata != {AckType, EthType});
        default: ;
      endcase
    end
  end

  // Flags from a previous frame are ignored while taking word 0.
  always_comb begin
    flagsNxt = ((state == IDLE) ? 5'b0 : misFlags) | wordMis;
    frameOk  = !(flagsNxt[FlagLocal] && flagsNxt[FlagBcast]) &&
               !flagsNxt[FlagSrc] && !flagsNxt[FlagType] && !flagsNxt[FlagStrb];
  end

  // Count as it would look with the current word merged in, so a frame ending
  // on PayloadEnd can load the ack count in the same cycle.
  always_comb begin
    countNxt = countShadow;
    for (int i = 0; i < CountWords; i++) begin
      if (wordIdx == 3'(4 + i)) countNxt[i*32 +: 32] = RvviAxiRdata;
    end
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= stateNxt;
  end

  // Next-state logic; also flags the two frame-completion outcomes.
  always_comb begin
    stateNxt = state;
    dropEvt  = 1'b0;
    holdEvt  = 1'b0;
    case (state)
      IDLE: begin
        if (xfer) begin
          if (RvviAxiRlast) dropEvt  = 1'b1;
          else              stateNxt = HEADER;
        end
      end
      HEADER: begin
        if (xfer) begin
          if (RvviAxiRlast) begin
            stateNxt = IDLE;
            dropEvt  = 1'b1;
          end else if (wordIdx == 3'd3) begin
            stateNxt = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (xfer) begin
          if (wordIdx == PayloadEnd) begin
            if (!RvviAxiRlast) begin
              stateNxt = DRAIN;
            end else if (frameOk) begin
              stateNxt = HOLD;
              holdEvt  = 1'b1;
            end else begin
              stateNxt = IDLE;
              dropEvt  = 1'b1;
            end
          end else if (RvviAxiRlast) begin
            stateNxt = IDLE;
            dropEvt  = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (xfer && RvviAxiRlast) begin
          if (frameOk) begin
            stateNxt = HOLD;
            holdEvt  = 1'b1;
          end else begin
            stateNxt = IDLE;
            dropEvt  = 1'b1;
          end
        end
      end
      HOLD: begin
        if (AckReady) stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    RvviAxiRready = (state != HOLD);
    AckValid      = (state == HOLD);
  end

  // Frame datapath: word index, mismatch flags, count capture.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wordIdx     <= '0;
      misFlags    <= '0;
      countShadow <= '0;
    end else if (xfer) begin
      misFlags    <= flagsNxt;
      countShadow <= countNxt;
      if (stateNxt == IDLE || stateNxt == HOLD) wordIdx <= '0;
      else if (wordIdx != IdxSat)               wordIdx <= wordIdx + 3'd1;
    end
  end

  // The ack count only moves when a validated frame enters HOLD, so it is
  // stable for the whole time AckValid is high.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ackCountQ <= '0;
      dropCntQ  <= '0;
    end else begin
      if (holdEvt) ackCountQ <= countNxt;
      if (dropEvt && dropCntQ != 16'hFFFF) dropCntQ <= dropCntQ + 16'd1;
    end
  end

endmodule

// File: tb/tb_rvvi_ack_receiver.sv
// tb/tb_rvvi_ack_receiver.sv - directed scoreboard bench for rvvi_ack_receiver
module tb_rvvi_ack_receiver;

  localparam logic [47:0] LOCAL_MAC  = 48'h02_00_00_00_00_01;
  localparam logic [47:0] REMOTE_MAC = 48'h02_00_00_00_00_02;
  localparam logic [47:0] BCAST_MAC  = 48'hFFFF_FFFF_FFFF;
  localparam logic [15:0] ETH_TYPE   = 16'h88B5;
  localparam logic [15:0] ACK_TYPE   = 16'h0001;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] RvviAxiRdata;
  logic [3:0]  RvviAxiRstrb;
  logic        RvviAxiRlast;
  logic        RvviAxiRvalid;
  logic        RvviAxiRready;
  logic        AckValid;
  logic        AckReady;
  logic [63:0] AckFrameCount;
  logic [15:0] DropCount;

  always #5 clk = ~clk;

  rvvi_ack_receiver #(.FRAME_COUNT_WIDTH(64)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .RvviAxiRdata (RvviAxiRdata),
    .RvviAxiRstrb (RvviAxiRstrb),
    .RvviAxiRlast (RvviAxiRlast),
    .RvviAxiRvalid(RvviAxiRvalid),
    .RvviAxiRready(RvviAxiRready),
    .LocalMac     (LOCAL_MAC),
    .RemoteMac    (REMOTE_MAC),
    .EthType      (ETH_TYPE),
    .AckType      (ACK_TYPE),
    .AckValid     (AckValid),
    .AckReady     (AckReady),
    .AckFrameCount(AckFrameCount),
    .DropCount    (DropCount)
  );

  typedef struct {
    bit          isAck;
    logic [63:0] cnt;
  } expT;

  expT         expQ[$];
  logic [15:0] expDrop;
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] frameW [16];
  logic [3:0]  frameS [16];
  logic [63:0] heldCount;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic buildFrame(input logic [47:0] dst, input logic [47:0] src,
                            input logic [15:0] eth, input logic [15:0] ack,
                            input logic [63:0] cnt);
    frameW[0] = dst[31:0];
    frameW[1] = {src[15:0], dst[47:32]};
    frameW[2] = src[47:16];
    frameW[3] = {ack, eth};
    frameW[4] = cnt[31:0];
    frameW[5] = cnt[63:32];
    for (int i = 6; i < 16; i++) frameW[i] = $urandom;
    for (int i = 0; i < 16; i++) frameS[i] = 4'hF;
  endtask

  task automatic sendWord(input logic [31:0] d, input logic [3:0] s, input bit l);
    int guard = 0;
    RvviAxiRdata  = d;
    RvviAxiRstrb  = s;
    RvviAxiRlast  = l;
    RvviAxiRvalid = 1'b1;
    while (RvviAxiRready !== 1'b1 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) check("ready_timeout", {63'b0, RvviAxiRready}, 64'd1);
    @(posedge clk); #1;
    RvviAxiRvalid = 1'b0;
    RvviAxiRlast  = 1'b0;
  endtask

  task automatic sendFrame(input int n);
    for (int i = 0; i < n; i++) sendWord(frameW[i], frameS[i], (i == n - 1));
  endtask

  // Pops the expected outcome of the frame just sent; called one cycle after its last word.
  task automatic checkOutcome(input string tag);
    expT e;
    e = expQ.pop_front();
    if (e.isAck) begin
      check({tag, "_ackvalid"}, {63'b0, AckValid}, 64'd1);
      check({tag, "_count"}, AckFrameCount, e.cnt);
      check({tag, "_ready_low"}, {63'b0, RvviAxiRready}, 64'd0);
      check({tag, "_drop"}, {48'b0, DropCount}, {48'b0, expDrop});
    end else begin
      if (expDrop != 16'hFFFF) expDrop = expDrop + 16'd1;
      check({tag, "_noack"}, {63'b0, AckValid}, 64'd0);
      check({tag, "_drop"}, {48'b0, DropCount}, {48'b0, expDrop});
    end
  endtask

  task automatic releaseAck(input string tag);
    AckReady = 1'b1;
    @(posedge clk); #1;
    AckReady = 1'b0;
    check({tag, "_ackvalid_drop"}, {63'b0, AckValid}, 64'd0);
    check({tag, "_ready_back"}, {63'b0, RvviAxiRready}, 64'd1);
  endtask

  function automatic expT mkExp(input bit isAck, input logic [63:0] cnt);
    expT e;
    e.isAck = isAck;
    e.cnt   = cnt;
    return e;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn        = 1'b0;
    RvviAxiRdata  = '0;
    RvviAxiRstrb  = '0;
    RvviAxiRlast  = 1'b0;
    RvviAxiRvalid = 1'b0;
    AckReady      = 1'b0;
    expDrop       = '0;
    heldCount     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ackvalid", {63'b0, AckValid}, 64'd0);
    check("rst_count", AckFrameCount, 64'd0);
    check("rst_drop", {48'b0, DropCount}, 64'd0);
    check("rst_ready", {63'b0, RvviAxiRready}, 64'd1);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Matching 6-word frame.
    buildFrame(LOCAL_MAC, REMOTE_MAC, ETH_TYPE, ACK_TYPE, 64'h0000_0001_0000_0007);
    expQ.push_back(mkExp(1'b1, 64'h0000_0001_0000_0007));
    sendFrame(6);
    checkOutcome("basic");
    releaseAck("basic");

    // Wrong AckType is rejected.
    buildFrame(LOCAL_MAC, REMOTE_MAC, ETH_TYPE, 16'h0002, 64'h0000_0000_0000_0099);
    expQ.push_back(mkExp(1'b0, '0));
    sendFrame(6);
    checkOutcome("acktype");

    // Long frame; trailing words carry zero strobes that must be ignored.
    buildFrame(LOCAL_MAC, REMOTE_MAC, ETH_TYPE, ACK_TYPE, 64'hDEAD_BEEF_1234_5678);
    for (int i = 6; i < 9; i++) frameS[i] = 4'h0;
    expQ.push_back(mkExp(1'b1, 64'hDEAD_BEEF_1234_5678));
    sendFrame(9);
    checkOutcome("long");
    releaseAck("long");

    // Early last on w3, then a broadcast-addressed valid frame.
    buildFrame(LOCAL_MAC, REMOTE_MAC, ETH_TYPE, ACK_TYPE, 64'h1);
    expQ.push_back(mkExp(1'b0, '0));
    sendFrame(4);
    checkOutcome("short");
    check("short_idle_ready", {63'b0, RvviAxiRready}, 64'd1);
    buildFrame(BCAST_MAC, REMOTE_MAC, ETH_TYPE, ACK_TYPE, 64'h0000_0000_0000_0005);
    expQ.push_back(mkExp(1'b1, 64'h5));
    sendFrame(6);
    checkOutcome("bcast");
    releaseAck("bcast");

    // Bad strobe inside the count field.
    buildFrame(LOCAL_MAC, REMOTE_MAC, ETH_TYPE, ACK_TYPE, 64'h77);
    frameS[4] = 4'h7;
    expQ.push_back(mkExp(1'b0, '0));
    sendFrame(6);
    checkOutcome("strb");

    // Wrong source address.
    buildFrame(LOCAL_MAC, 48'h02_00_00_00_00_03, ETH_TYPE, ACK_TYPE, 64'h88);
    expQ.push_back(mkExp(1'b0, '0));
    sendFrame(7);
    checkOutcome("src");

    // Ack held for 20 cycles while a second frame waits.
    buildFrame(LOCAL_MAC, REMOTE_MAC, ETH_TYPE, ACK_TYPE, 64'h0000_00AA_0000_0011);
    expQ.push_back(mkExp(1'b1, 64'h0000_00AA_0000_0011));
    sendFrame(6);
    checkOutcome("hold1");
    heldCount = 64'h0000_00AA_0000_0011;
    buildFrame(LOCAL_MAC, REMOTE_MAC, ETH_TYPE, ACK_TYPE, 64'h0000_00BB_0000_0022);
    RvviAxiRdata  = frameW[0];
    RvviAxiRstrb  = frameS[0];
    RvviAxiRlast  = 1'b0;
    RvviAxiRvalid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      check("hold_ready_low", {63'b0, RvviAxiRready}, 64'd0);
      check("hold_count_stable", AckFrameCount, heldCount);
    end
    releaseAck("hold1");
    expQ.push_back(mkExp(1'b1, 64'h0000_00BB_0000_0022));
    sendFrame(6);
    checkOutcome("hold2");
    releaseAck("hold2");

    // Reset asserted while w2 is on the bus.
    buildFrame(LOCAL_MAC, REMOTE_MAC, ETH_TYPE, ACK_TYPE, 64'h33);
    sendWord(frameW[0], 4'hF, 1'b0);
    sendWord(frameW[1], 4'hF, 1'b0);
    RvviAxiRdata  = frameW[2];
    RvviAxiRvalid = 1'b1;
    #2;
    resetn = 1'b0;
    #1;
    check("midrst_drop", {48'b0, DropCount}, 64'd0);
    check("midrst_ackvalid", {63'b0, AckValid}, 64'd0);
    check("midrst_count", AckFrameCount, 64'd0);
    check("midrst_ready", {63'b0, RvviAxiRready}, 64'd1);
    @(posedge clk); #1;
    RvviAxiRvalid = 1'b0;
    resetn        = 1'b1;
    expDrop       = '0;
    @(posedge clk); #1;
    buildFrame(LOCAL_MAC, REMOTE_MAC, ETH_TYPE, ACK_TYPE, 64'h0000_0002_0000_0044);
    expQ.push_back(mkExp(1'b1, 64'h0000_0002_0000_0044));
    sendFrame(6);
    checkOutcome("postrst");
    releaseAck("postrst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
